// File: rtl/io_register_bank.sv
// io_register_bank
//   Memory-mapped I/O bank between the CPU data path and the board peripherals.
//   Holds the display registers, an LED register and a control register, and
//   samples the board switches through a 2-flop synchroniser plus a per-bit
//   debouncer. Debounced rising edges set sticky event flags that can raise irq.
//
//   Register map (full ADDR_LEN decode, unmapped reads return 0):
//     0x0..CH-1  DISP[i]   RW
//     0x8        SW_STATE  RO  debounced switches, zero-extended
//     0x9        SW_EVENT  R/W1C, a read also clears the bits it returned
//     0xA        LED       RW  SWITCH_SIZE-1 bits
//     0xB        CTRL      RW  bit0 blank, bit1 irq_en
//
// Ports
//   slow_clock, reset      clock, synchronous active-high reset
//   enable                 CPU run flag, gates the green LED status view
//   addr, wr_en, wr_data   register write port
//   rd_en, rd_data,        register read port, 1-cycle latency;
//   rd_valid               rd_data holds between reads
//   switches               raw asynchronous board switches
//   status                 {Neg,Zero,Carry,V,M}
//   disp_data              display registers, channel i at [i*DATA_SIZE +: DATA_SIZE]
//   red_leds, green_leds   LED register and registered status view
//   irq                    switch-event interrupt, level
module io_register_bank #(
   parameter int DATA_SIZE        = 32,
   parameter int SWITCH_SIZE      = 16,
   parameter int DISPLAY_CHANNELS = 2,
   parameter int DEBOUNCE_CYCLES  = 4,
   parameter int ADDR_LEN         = 4
) (
   input  logic                                 slow_clock,
   input  logic                                 reset,
   input  logic                                 enable,
   input  logic [ADDR_LEN-1:0]                  addr,
   input  logic                                 wr_en,
   input  logic [DATA_SIZE-1:0]                 wr_data,
   input  logic                                 rd_en,
   output logic [DATA_SIZE-1:0]                 rd_data,
   output logic                                 rd_valid,
   input  logic [SWITCH_SIZE-1:0]               switches,
   input  logic [4:0]                           status,
   output logic [DISPLAY_CHANNELS*DATA_SIZE-1:0] disp_data,
   output logic [SWITCH_SIZE-2:0]               red_leds,
   output logic [4:0]                           green_leds,
   output logic                                 irq
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [ADDR_LEN-1:0] ADDR_SW_STATE = ADDR_LEN'(8);
   localparam logic [ADDR_LEN-1:0] ADDR_SW_EVENT = ADDR_LEN'(9);
   localparam logic [ADDR_LEN-1:0] ADDR_LED      = ADDR_LEN'(10);
   localparam logic [ADDR_LEN-1:0] ADDR_CTRL     = ADDR_LEN'(11);

   logic [DATA_SIZE-1:0]   disp [DISPLAY_CHANNELS];
   logic [SWITCH_SIZE-2:0] led;
   logic                   ctrl_blank;
   logic                   ctrl_irq_en;
   logic [SWITCH_SIZE-1:0] sw_state;
   logic [SWITCH_SIZE-1:0] sw_event;
   logic [SWITCH_SIZE-1:0] sync_1;
   logic [SWITCH_SIZE-1:0] sync_2;
   logic [CNT_W-1:0]       cnt      [SWITCH_SIZE];
   logic [CNT_W-1:0]       cnt_next [SWITCH_SIZE];

   logic [DISPLAY_CHANNELS-1:0] disp_hit;
   logic                        event_hit;
   logic [DATA_SIZE-1:0]        rd_mux;
   logic [SWITCH_SIZE-1:0]      sw_state_next;
   logic [SWITCH_SIZE-1:0]      sw_rise;
   logic [SWITCH_SIZE-1:0]      event_clr;

   // address decode and read mux
   always_comb begin
      disp_hit  = '0;
      event_hit = (addr == ADDR_SW_EVENT);
      rd_mux    = '0;
      for (int i = 0; i < DISPLAY_CHANNELS; i++) begin
         if (addr == ADDR_LEN'(i)) begin
            disp_hit[i] = 1'b1;
            rd_mux      = disp[i];
         end
      end
      if (addr == ADDR_SW_STATE) rd_mux = DATA_SIZE'(sw_state);
      if (event_hit)             rd_mux = DATA_SIZE'(sw_event);
      if (addr == ADDR_LED)      rd_mux = DATA_SIZE'(led);
      if (addr == ADDR_CTRL)     rd_mux = DATA_SIZE'({ctrl_irq_en, ctrl_blank});
   end

   // per-bit debounce: count consecutive cycles the synchronised bit disagrees
   // with the accepted state; accept on the DEBOUNCE_CYCLES-th such cycle
   always_comb begin
      sw_state_next = sw_state;
      sw_rise       = '0;
      for (int b = 0; b < SWITCH_SIZE; b++) begin
         cnt_next[b] = '0;
         if (sync_2[b] != sw_state[b]) begin
            if (cnt[b] == CNT_MAX) begin
               sw_state_next[b] = sync_2[b];
               sw_rise[b]       = sync_2[b];
            end else begin
               cnt_next[b] = cnt[b] + CNT_W'(1);
            end
         end
      end
   end

   // a read of SW_EVENT clears exactly the bits it returns; W1C clears written ones
   always_comb begin
      event_clr = '0;
      if (rd_en && event_hit) event_clr = event_clr | sw_event;
      if (wr_en && event_hit) event_clr = event_clr | wr_data[SWITCH_SIZE-1:0];
   end

   always_ff @(posedge slow_clock) begin
      if (reset) begin
         for (int i = 0; i < DISPLAY_CHANNELS; i++) disp[i] <= '0;
         for (int b = 0; b < SWITCH_SIZE; b++)      cnt[b]  <= '0;
         led         <= '0;
         ctrl_blank  <= 1'b0;
         ctrl_irq_en <= 1'b0;
         sw_state    <= '0;
         sw_event    <= '0;
         sync_1      <= '0;
         sync_2      <= '0;
         rd_data     <= '0;
         rd_valid    <= 1'b0;
         irq         <= 1'b0;
         green_leds  <= '0;
      end else begin
         for (int i = 0; i < DISPLAY_CHANNELS; i++) begin
            if (wr_en && disp_hit[i]) disp[i] <= wr_data;
         end
         if (wr_en && addr == ADDR_LED) led <= wr_data[SWITCH_SIZE-2:0];
         if (wr_en && addr == ADDR_CTRL) begin
            ctrl_blank  <= wr_data[0];
            ctrl_irq_en <= wr_data[1];
         end

         sync_1   <= switches;
         sync_2   <= sync_1;
         for (int b = 0; b < SWITCH_SIZE; b++) cnt[b] <= cnt_next[b];
         sw_state <= sw_state_next;
         // set has priority over a same-cycle clear
         sw_event <= (sw_event & ~event_clr) | sw_rise;

         // rd_mux sees pre-write register values, so read-during-write returns old data
         if (rd_en) rd_data <= rd_mux;
         rd_valid <= rd_en;

         irq        <= ctrl_irq_en & (|sw_event);
         green_leds <= {(enable ? status[4:1] : 4'hF), status[0]};
      end
   end

   always_comb begin
      disp_data = '0;
      for (int i = 0; i < DISPLAY_CHANNELS; i++) begin
         disp_data[i*DATA_SIZE +: DATA_SIZE] = ctrl_blank ? '0 : disp[i];
      end
   end

   assign red_leds = led;

endmodule

// File: tb/tb_io_register_bank.sv
module tb_io_register_bank;

   localparam int DS = 32;
   localparam int SS = 16;
   localparam int CH = 2;
   localparam int DB = 4;
   localparam int AL = 4;

   logic          slow_clock = 1'b0;
   logic          reset;
   logic          enable;
   logic [AL-1:0] addr;
   logic          wr_en;
   logic [DS-1:0] wr_data;
   logic          rd_en;
   logic [DS-1:0] rd_data;
   logic          rd_valid;
   logic [SS-1:0] switches;
   logic [4:0]    status;
   logic [CH*DS-1:0] disp_data;
   logic [SS-2:0] red_leds;
   logic [4:0]    green_leds;
   logic          irq;

   io_register_bank #(
      .DATA_SIZE(DS), .SWITCH_SIZE(SS), .DISPLAY_CHANNELS(CH),
      .DEBOUNCE_CYCLES(DB), .ADDR_LEN(AL)
   ) dut (
      .slow_clock(slow_clock), .reset(reset), .enable(enable),
      .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .switches(switches), .status(status), .disp_data(disp_data),
      .red_leds(red_leds), .green_leds(green_leds), .irq(irq)
   );

   always #5 slow_clock = ~slow_clock;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // reference model: register contents plus a history of raw switch samples;
   // a bit is accepted once the DB samples seen through the 2-stage
   // synchroniser all disagree with the current debounced value
   logic [31:0] m_disp [CH];
   logic [14:0] m_led;
   logic [1:0]  m_ctrl;
   logic [15:0] m_state;
   logic [15:0] m_ev;
   logic [31:0] m_rd_data;
   logic        m_rd_valid;
   logic        m_irq;
   logic [4:0]  m_green;
   logic [15:0] hist [0:DB];

   function automatic logic [31:0] m_read(input logic [3:0] a);
      case (a)
         4'h0:    return m_disp[0];
         4'h1:    return m_disp[1];
         4'h8:    return {16'h0, m_state};
         4'h9:    return {16'h0, m_ev};
         4'hA:    return {17'h0, m_led};
         4'hB:    return {30'h0, m_ctrl};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_step();
      logic [15:0] new_state;
      logic [15:0] rise;
      logic [15:0] clr;
      logic        all_diff;
      if (reset) begin
         m_disp[0] = '0; m_disp[1] = '0;
         m_led = '0; m_ctrl = '0; m_state = '0; m_ev = '0;
         m_rd_data = '0; m_rd_valid = 1'b0; m_irq = 1'b0; m_green = '0;
         for (int j = 0; j <= DB; j++) hist[j] = '0;
         return;
      end
      new_state = m_state;
      rise      = '0;
      for (int b = 0; b < SS; b++) begin
         all_diff = 1'b1;
         for (int j = 1; j <= DB; j++) if (hist[j][b] == m_state[b]) all_diff = 1'b0;
         if (all_diff) begin
            new_state[b] = ~m_state[b];
            rise[b]      = ~m_state[b];
         end
      end
      clr = '0;
      if (rd_en && addr == 4'h9) clr = clr | m_ev;
      if (wr_en && addr == 4'h9) clr = clr | wr_data[15:0];
      if (rd_en) m_rd_data = m_read(addr);
      m_rd_valid = rd_en;
      m_irq      = m_ctrl[1] && (m_ev != 0);
      m_green    = {(enable ? status[4:1] : 4'hF), status[0]};
      if (wr_en) begin
         if (addr < 4'(CH)) m_disp[addr[0]] = wr_data;
         if (addr == 4'hA)  m_led  = wr_data[14:0];
         if (addr == 4'hB)  m_ctrl = wr_data[1:0];
      end
      m_ev    = (m_ev & ~clr) | rise;
      m_state = new_state;
      for (int j = DB; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = switches;
   endtask

   task automatic check_outputs();
      logic [63:0] exp_disp;
      exp_disp = m_ctrl[0] ? 64'h0 : {m_disp[1], m_disp[0]};
      check_val("rd_valid",   64'(rd_valid),   64'(m_rd_valid));
      check_val("rd_data",    64'(rd_data),    64'(m_rd_data));
      check_val("disp_data",  disp_data,       exp_disp);
      check_val("red_leds",   64'(red_leds),   64'(m_led));
      check_val("green_leds", 64'(green_leds), 64'(m_green));
      check_val("irq",        64'(irq),        64'(m_irq));
   endtask

   task automatic tick();
      @(posedge slow_clock);
      model_step();
      @(negedge slow_clock);
      check_outputs();
   endtask

   task automatic bus(input logic w, input logic r, input logic [3:0] a, input logic [31:0] d);
      wr_en = w; rd_en = r; addr = a; wr_data = d;
   endtask

   task automatic idle();
      bus(1'b0, 1'b0, 4'h0, 32'h0);
   endtask

   logic [3:0] addr_pool [10];

   initial begin
      addr_pool = '{4'h0, 4'h1, 4'h2, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hF};
      reset = 1'b1; enable = 1'b1; status = 5'h0; switches = '0;
      idle();
      tick(); tick();
      check_val("rst_rd_valid", 64'(rd_valid), 64'h0);
      check_val("rst_disp",     disp_data,     64'h0);
      check_val("rst_irq",      64'(irq),      64'h0);
      reset = 1'b0;

      // display write and read-back
      bus(1'b1, 1'b0, 4'h0, 32'h12345678); tick();
      bus(1'b1, 1'b0, 4'h1, 32'hCAFEBABE); tick();
      bus(1'b0, 1'b1, 4'h1, 32'h0);        tick();
      check_val("rd1_valid", 64'(rd_valid), 64'h1);
      check_val("rd1_data",  64'(rd_data),  64'hCAFEBABE);
      check_val("disp_both", disp_data,     64'hCAFEBABE_12345678);

      // blanking leaves stored values intact
      bus(1'b1, 1'b0, 4'hB, 32'h1); tick();
      check_val("blanked", disp_data, 64'h0);
      bus(1'b0, 1'b1, 4'h0, 32'h0); tick();
      check_val("rd0_blank", 64'(rd_data), 64'h12345678);
      bus(1'b1, 1'b0, 4'hB, 32'h0); tick();
      check_val("unblanked", disp_data, 64'hCAFEBABE_12345678);

      // switch bit3 debounce latency, event, irq, read-to-clear
      bus(1'b1, 1'b0, 4'hB, 32'h2); tick();
      switches = 16'h0008;
      bus(1'b0, 1'b1, 4'h8, 32'h0);
      for (int i = 0; i < 6; i++) tick();
      check_val("sw_before6", 64'(rd_data), 64'h0);
      tick();
      check_val("sw_after6", 64'(rd_data), 64'h8);
      check_val("irq_set",   64'(irq),     64'h1);
      bus(1'b0, 1'b1, 4'h9, 32'h0); tick();
      check_val("ev_read", 64'(rd_data), 64'h8);
      idle(); tick();
      check_val("irq_drop", 64'(irq), 64'h0);

      // 3-cycle glitch on bit5
      switches = 16'h0028; tick(); tick(); tick();
      switches = 16'h0008;
      for (int i = 0; i < 8; i++) tick();
      bus(1'b0, 1'b1, 4'h8, 32'h0); tick();
      check_val("glitch_state", 64'(rd_data), 64'h8);
      bus(1'b0, 1'b1, 4'h9, 32'h0); tick();
      check_val("glitch_event", 64'(rd_data), 64'h0);

      // event set coincides with W1C write
      idle();
      switches = 16'h0009;
      for (int i = 0; i < 5; i++) tick();
      bus(1'b1, 1'b0, 4'h9, 32'hFFFF); tick();
      idle(); tick();
      bus(1'b0, 1'b1, 4'h9, 32'h0); tick();
      check_val("set_wins", 64'(rd_data), 64'h1);

      // reset with live registers and a read in flight
      bus(1'b1, 1'b0, 4'hA, 32'h7FFF); tick();
      bus(1'b1, 1'b0, 4'hB, 32'h3); tick();
      idle();
      switches = 16'h000D;
      for (int i = 0; i < 8; i++) tick();
      check_val("irq_pre_rst", 64'(irq), 64'h1);
      bus(1'b0, 1'b1, 4'h1, 32'h0); tick();
      reset = 1'b1; tick();
      check_val("rst_rdv",  64'(rd_valid), 64'h0);
      check_val("rst_irq2", 64'(irq),      64'h0);
      check_val("rst_red",  64'(red_leds), 64'h0);
      check_val("rst_disp2", disp_data,    64'h0);
      reset = 1'b0;
      idle();

      // green LED gating
      enable = 1'b0; status = 5'b00001; tick();
      check_val("green_dis", 64'(green_leds), 64'h1F);
      enable = 1'b1; tick();
      check_val("green_en",  64'(green_leds), 64'h01);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         reset   = ($urandom_range(0, 399) == 0);
         enable  = 1'($urandom_range(0, 1));
         status  = 5'($urandom);
         wr_en   = ($urandom_range(0, 2) == 0);
         rd_en   = 1'($urandom_range(0, 1));
         addr    = addr_pool[$urandom_range(0, 9)];
         wr_data = ($urandom_range(0, 7) == 0) ? 32'hFFFF : $urandom;
         if ($urandom_range(0, 5) == 0) switches[$urandom_range(0, 7)] ^= 1'b1;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
